// File: rtl/trace_filter_ctrl.sv
// Trace filter sequencer: start/stop-PC trigger FSM, drop/bypass gating and a
// one-deep valid/ready output register. Optional TRACE_CTRL_TIMESTAMP_EN adds trace_ts.
module trace_filter_ctrl #(
  parameter int PC_W  = 64,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_wr_en,
  input  logic [1:0]       cfg_addr,
  input  logic [PC_W-1:0]  cfg_wdata,
  input  logic [PC_W-1:0]  pc_in,
  input  logic [31:0]      instr_in,
  input  logic             instr_valid,
  output logic [31:0]      filter_instr,
  input  logic             filter_drop,
  output logic [PC_W-1:0]  trace_pc,
  output logic [31:0]      trace_instr,
  output logic             trace_valid,
  input  logic             trace_ready,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] kept_count,
  output logic [CNT_W-1:0] drop_count,
  output logic [CNT_W-1:0] ovf_count,
  output logic             ovf_sticky
`ifdef TRACE_CTRL_TIMESTAMP_EN
  ,
  output logic [63:0]      trace_ts
`endif
);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_ARMED = 2'd1, S_ACTIVE = 2'd2, S_DONE = 2'd3} state_t;

  state_t           r_state;
  logic [PC_W-1:0]  r_start, r_stop, r_pc;
  logic [31:0]      r_instr;
  logic             r_bypass, r_valid, r_sticky;
  logic [CNT_W-1:0] r_kept, r_drop, r_ovf;

  logic w_ctrl_wr, w_arm, w_disarm, w_clear;
  logic w_start_hit, w_stop_hit, w_in_window, w_eligible, w_dropped;
  logic w_slot_free, w_load, w_ovf;
  logic w_unused;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  assign filter_instr = instr_in;

  assign w_ctrl_wr = cfg_wr_en && (cfg_addr == 2'd0);
  assign w_arm     = w_ctrl_wr &&  cfg_wdata[0];
  assign w_disarm  = w_ctrl_wr && !cfg_wdata[0];
  assign w_clear   = w_ctrl_wr &&  cfg_wdata[1];
  assign w_unused  = &{1'b0, cfg_wdata[PC_W-1:3]};

  // A disarm write in the same cycle suppresses any trigger and eligibility.
  assign w_start_hit = (r_state == S_ARMED)  && instr_valid && (pc_in == r_start) && !w_disarm;
  assign w_stop_hit  = (r_state == S_ACTIVE) && instr_valid && (pc_in == r_stop)  && !w_disarm;
  assign w_in_window = instr_valid && !w_disarm && ((r_state == S_ACTIVE) || w_start_hit);
  assign w_eligible  = w_in_window && (r_bypass || !filter_drop);
  assign w_dropped   = w_in_window && !r_bypass && filter_drop;

  assign w_slot_free = !r_valid || trace_ready;
  assign w_load      = w_eligible &&  w_slot_free;
  assign w_ovf       = w_eligible && !w_slot_free;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else if (w_disarm) begin
      r_state <= S_IDLE;
    end else begin
      case (r_state)
        S_IDLE:   if (w_arm) r_state <= S_ARMED;
        S_ARMED:  if (w_start_hit) r_state <= (r_start == r_stop) ? S_DONE : S_ACTIVE;
        S_ACTIVE: if (w_stop_hit) r_state <= S_DONE;
        S_DONE:   if (w_arm) r_state <= S_ARMED;
        default:  r_state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_start  <= '0;
      r_stop   <= '0;
      r_bypass <= 1'b0;
    end else if (cfg_wr_en) begin
      case (cfg_addr)
        2'd0:    r_bypass <= cfg_wdata[2];
        2'd1:    r_start  <= cfg_wdata;
        2'd2:    r_stop   <= cfg_wdata;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_pc    <= '0;
      r_instr <= '0;
    end else if (w_load) begin
      r_valid <= 1'b1;
      r_pc    <= pc_in;
      r_instr <= instr_in;
    end else if (trace_ready) begin
      r_valid <= 1'b0;
    end
  end

  // Clear takes precedence over any increment sampled on the same edge.
  always_ff @(posedge clk) begin
    if (rst || w_clear) begin
      r_kept   <= '0;
      r_drop   <= '0;
      r_ovf    <= '0;
      r_sticky <= 1'b0;
    end else begin
      if (w_load)    r_kept <= sat_inc(r_kept);
      if (w_dropped) r_drop <= sat_inc(r_drop);
      if (w_ovf) begin
        r_ovf    <= sat_inc(r_ovf);
        r_sticky <= 1'b1;
      end
    end
  end

`ifdef TRACE_CTRL_TIMESTAMP_EN
  logic [63:0] r_ts_cnt, r_ts;

  always_ff @(posedge clk) begin
    if (rst || (cfg_wr_en && cfg_addr == 2'd3)) r_ts_cnt <= '0;
    else                                        r_ts_cnt <= r_ts_cnt + 64'd1;
  end

  always_ff @(posedge clk) begin
    if (rst)         r_ts <= '0;
    else if (w_load) r_ts <= r_ts_cnt;
  end

  assign trace_ts = r_ts;
`endif

  assign state       = r_state;
  assign trace_pc    = r_pc;
  assign trace_instr = r_instr;
  assign trace_valid = r_valid;
  assign kept_count  = r_kept;
  assign drop_count  = r_drop;
  assign ovf_count   = r_ovf;
  assign ovf_sticky  = r_sticky;

endmodule

// File: tb/tb_trace_filter_ctrl.sv
// Directed bench for trace_filter_ctrl; inputs driven 1ns after posedge, outputs checked there.
module tb_trace_filter_ctrl;
  localparam int PC_W  = 64;
  localparam int CNT_W = 32;

  logic             clk = 1'b0;
  logic             rst;
  logic             cfg_wr_en;
  logic [1:0]       cfg_addr;
  logic [PC_W-1:0]  cfg_wdata;
  logic [PC_W-1:0]  pc_in;
  logic [31:0]      instr_in;
  logic             instr_valid;
  logic [31:0]      filter_instr;
  logic             filter_drop;
  logic [PC_W-1:0]  trace_pc;
  logic [31:0]      trace_instr;
  logic             trace_valid;
  logic             trace_ready;
  logic [1:0]       state;
  logic [CNT_W-1:0] kept_count, drop_count, ovf_count;
  logic             ovf_sticky;
`ifdef TRACE_CTRL_TIMESTAMP_EN
  logic [63:0]      trace_ts;
  logic [63:0]      ts_exp;
`endif

  int n_checks = 0;
  int n_err    = 0;
  int ts_k     = 0;

  always #5 clk = ~clk;

  trace_filter_ctrl #(.PC_W(PC_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .cfg_wr_en(cfg_wr_en), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata),
    .pc_in(pc_in), .instr_in(instr_in), .instr_valid(instr_valid),
    .filter_instr(filter_instr), .filter_drop(filter_drop),
    .trace_pc(trace_pc), .trace_instr(trace_instr), .trace_valid(trace_valid),
    .trace_ready(trace_ready), .state(state),
    .kept_count(kept_count), .drop_count(drop_count), .ovf_count(ovf_count),
    .ovf_sticky(ovf_sticky)
`ifdef TRACE_CTRL_TIMESTAMP_EN
    , .trace_ts(trace_ts)
`endif
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    ts_k++;
  endtask

  task automatic cfg(input logic [1:0] a, input logic [63:0] d);
    cfg_wr_en = 1'b1; cfg_addr = a; cfg_wdata = d;
    step();
    cfg_wr_en = 1'b0; cfg_addr = 2'd0; cfg_wdata = '0;
  endtask

  task automatic feed(input logic [63:0] p, input logic [31:0] ins, input logic drp);
    instr_valid = 1'b1; pc_in = p; instr_in = ins; filter_drop = drp;
    step();
  endtask

  task automatic idle();
    instr_valid = 1'b0; filter_drop = 1'b0;
    step();
  endtask

  initial begin
    logic [63:0] p;
    logic        ev;
    logic [31:0] ins [3];
    ins[0] = 32'h0000006f; ins[1] = 32'h00000067; ins[2] = 32'h00000013;

    rst = 1'b1; cfg_wr_en = 1'b0; cfg_addr = '0; cfg_wdata = '0;
    pc_in = '0; instr_in = '0; instr_valid = 1'b0; filter_drop = 1'b0; trace_ready = 1'b1;
    step(); step();
    rst = 1'b0;
    chk("rst_state", state, 0);
    chk("rst_valid", trace_valid, 0);
    chk("rst_pc", trace_pc, 0);
    chk("rst_instr", trace_instr, 0);
    chk("rst_kept", kept_count, 0);
    chk("rst_ovf", {ovf_sticky, ovf_count}, 0);

    // 1: start/stop window
    cfg(2'd1, 64'h100);
    cfg(2'd2, 64'h10C);
    cfg(2'd0, 64'h1);
    chk("t1_armed", state, 1);
    instr_in = 32'h13;
    #1 chk("t1_passthru", filter_instr, 32'h13);
    for (int i = 0; i < 7; i++) begin
      p  = 64'hF8 + 64'(4 * i);
      feed(p, 32'h13, 1'b0);
      ev = (p >= 64'h100) && (p <= 64'h10C);
      chk("t1_valid", trace_valid, ev);
      if (ev) chk("t1_pc", trace_pc, p);
    end
    idle();
    chk("t1_kept", kept_count, 4);
    chk("t1_done", state, 3);
    chk("t1_drained", trace_valid, 0);

    // 2: filter drops, then bypass
    cfg(2'd0, 64'h1);
    chk("t2_rearm", state, 1);
    feed(64'h100, 32'h13, 1'b0);
    chk("t2_active", state, 2);
    feed(64'h200, ins[0], 1'b1);
    chk("t2_drop1_valid", trace_valid, 0);
    feed(64'h204, ins[1], 1'b1);
    chk("t2_drop2_valid", trace_valid, 0);
    feed(64'h208, ins[2], 1'b0);
    chk("t2_addi_valid", trace_valid, 1);
    chk("t2_addi_instr", trace_instr, 32'h13);
    idle();
    chk("t2_drop_cnt", drop_count, 2);
    chk("t2_kept", kept_count, 6);
    cfg(2'd0, 64'h5);
    chk("t2_still_active", state, 2);
    for (int i = 0; i < 3; i++) begin
      feed(64'h300 + 64'(4 * i), ins[i], 1'b1);
      chk("t2_byp_valid", trace_valid, 1);
      chk("t2_byp_instr", trace_instr, ins[i]);
    end
    idle();
    chk("t2_byp_drop_cnt", drop_count, 2);
    chk("t2_byp_kept", kept_count, 9);

    // 3: backpressure and overflow
    trace_ready = 1'b0;
    feed(64'h400, 32'h13, 1'b0);
    chk("t3_first_valid", trace_valid, 1);
    feed(64'h404, 32'h14, 1'b0);
    chk("t3_hold_pc", trace_pc, 64'h400);
    feed(64'h408, 32'h15, 1'b0);
    chk("t3_hold_pc2", trace_pc, 64'h400);
    chk("t3_hold_instr", trace_instr, 32'h13);
    chk("t3_ovf", ovf_count, 2);
    chk("t3_sticky", ovf_sticky, 1);
    trace_ready = 1'b1;
    idle();
    chk("t3_accept", trace_valid, 0);
    chk("t3_kept", kept_count, 10);
    trace_ready = 1'b0;
    feed(64'h500, 32'h13, 1'b0);
    chk("t3_load_a", trace_pc, 64'h500);
    trace_ready = 1'b1;
    feed(64'h504, 32'h13, 1'b0);
    chk("t3_b2b_valid", trace_valid, 1);
    chk("t3_b2b_pc", trace_pc, 64'h504);
    chk("t3_b2b_kept", kept_count, 12);
    idle();
    chk("t3_b2b_drain", trace_valid, 0);

    // 4: start==stop goes straight to DONE
    cfg(2'd1, 64'h200);
    cfg(2'd2, 64'h200);
    cfg(2'd0, 64'h0);
    chk("t4_idle", state, 0);
    cfg(2'd0, 64'h1);
    chk("t4_armed", state, 1);
    feed(64'h200, 32'h13, 1'b0);
    chk("t4_done", state, 3);
    chk("t4_valid", trace_valid, 1);
    chk("t4_pc", trace_pc, 64'h200);
    idle();
    chk("t4_kept", kept_count, 13);
    cfg(2'd0, 64'h1);
    chk("t4_rearm", state, 1);

    // 5: disarm beats trigger; clear
    cfg_wr_en = 1'b1; cfg_addr = 2'd0; cfg_wdata = 64'h0;
    feed(64'h200, 32'h13, 1'b0);
    cfg_wr_en = 1'b0;
    chk("t5_idle", state, 0);
    chk("t5_no_out", trace_valid, 0);
    chk("t5_kept", kept_count, 13);
    idle();
    cfg(2'd0, 64'h2);
    chk("t5_clr_kept", kept_count, 0);
    chk("t5_clr_drop", drop_count, 0);
    chk("t5_clr_ovf", ovf_count, 0);
    chk("t5_clr_sticky", ovf_sticky, 0);

    // 6: reset mid-operation
    cfg(2'd1, 64'h600);
    cfg(2'd0, 64'h1);
    trace_ready = 1'b0;
    feed(64'h600, 32'h13, 1'b0);
    feed(64'h604, 32'h6f, 1'b1);
    chk("t6_pre_valid", trace_valid, 1);
    chk("t6_pre_state", state, 2);
    chk("t6_pre_drop", drop_count, 1);
    rst = 1'b1; instr_valid = 1'b0; filter_drop = 1'b0;
    step();
    rst = 1'b0;
    ts_k = 0;
    chk("t6_state", state, 0);
    chk("t6_valid", trace_valid, 0);
    chk("t6_pc", trace_pc, 0);
    chk("t6_instr", trace_instr, 0);
    chk("t6_cnts", {kept_count, drop_count}, 0);
    // start/stop both back at 0: pc 0 triggers straight to DONE
    cfg(2'd0, 64'h1);
    feed(64'h0, 32'h13, 1'b0);
    chk("t6_pc0_valid", trace_valid, 1);
    chk("t6_pc0_state", state, 3);
`ifdef TRACE_CTRL_TIMESTAMP_EN
    ts_exp = 64'(ts_k - 1);
    chk("t6_ts_load", trace_ts, ts_exp);
    idle();
    chk("t6_ts_hold", trace_ts, ts_exp);
`else
    idle();
`endif
    chk("t6_pc0_hold", trace_pc, 0);
    trace_ready = 1'b1;
    idle();
    chk("t6_final_drain", trace_valid, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: observed no finish, expected finish");
    $fatal(1, "timeout");
  end
endmodule
